// File: rtl/fpack_seq.sv
// fpack_seq: packs an internal max-precision FP value into the IEEE encoding of the
// selected format, NaN-boxed to FLEN. Subnormal results are denormalized one bit per
// cycle in SHIFT before being presented in DONE.
module fpack_seq #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned NE      = 11,
  parameter int unsigned NF      = 52,
  parameter int unsigned FMTBITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [FMTBITS-1:0] Fmt,
  input  logic               Xs,
  input  logic [NE-1:0]      Xe,
  input  logic [NF:0]        Xm,
  input  logic               XNaN,
  input  logic               XInf,
  input  logic               XZero,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [FLEN-1:0]    Result,
  output logic               Inexact,
  output logic               Overflow,
  output logic               Underflow
);

  localparam int          BiasMax = (1 << (NE - 1)) - 1;
  localparam int unsigned PW      = (FLEN > 128) ? FLEN : 128;
  localparam int unsigned CntW    = 8;
  localparam int unsigned EtW     = NE + 2;
  localparam logic [PW-1:0] OneW  = PW'(1);
  localparam logic [PW-1:0] OnesW = '1;
  // Widest format that fits in FLEN; its canonical NaN answers unsupported formats
  localparam logic [1:0] WideFmt = (FLEN >= 128) ? 2'b11 :
                                   (FLEN >= 64)  ? 2'b01 :
                                   (FLEN >= 32)  ? 2'b00 : 2'b10;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  function automatic int fmt_e(input logic [1:0] f);
    case (f)
      2'b00:   fmt_e = 8;
      2'b01:   fmt_e = 11;
      2'b10:   fmt_e = 5;
      default: fmt_e = 15;
    endcase
  endfunction

  function automatic int fmt_nf(input logic [1:0] f);
    case (f)
      2'b00:   fmt_nf = 23;
      2'b01:   fmt_nf = 52;
      2'b10:   fmt_nf = 10;
      default: fmt_nf = 112;
    endcase
  endfunction

  logic [1:0]      state_q, state_d, fmt_q, fmt_d;
  logic            sign_q, sign_d, sticky_q, sticky_d, sticky_sh;
  logic [NF:0]     mant_q, mant_d, mant_sh;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [FLEN-1:0] result_q, result_d;
  logic            inexact_q, inexact_d, overflow_q, overflow_d, underflow_q, underflow_d;

  logic                  use_shift, p_sign, dropped, cur_supported;
  logic [1:0]            p_fmt;
  int                    p_e, p_nf, p_w, w_e, w_nf, box_w, et_i;
  logic signed [EtW-1:0] et_v;
  logic [PW-1:0]         ext, frac, emask, word;
  logic [FLEN-1:0]       pk_result;
  logic                  pk_inexact, pk_overflow, pk_underflow;

  assign mant_sh   = mant_q >> 1;
  assign sticky_sh = sticky_q | mant_q[0];

  // Packer: fresh inputs in IDLE, the just-shifted operand on the last SHIFT cycle
  always_comb begin
    use_shift     = (state_q == StShift);
    p_fmt         = use_shift ? fmt_q : Fmt[1:0];
    p_sign        = use_shift ? sign_q : Xs;
    p_e           = fmt_e(p_fmt);
    p_nf          = fmt_nf(p_fmt);
    p_w           = 1 + p_e + p_nf;
    box_w         = p_w;
    cur_supported = (p_w <= int'(FLEN));
    et_v          = EtW'(int'(Xe) - BiasMax + ((1 << (p_e - 1)) - 1));
    et_i          = int'(et_v);
    ext           = use_shift ? PW'(mant_sh[NF-1:0]) : PW'(Xm[NF-1:0]);
    if (p_nf <= int'(NF)) begin
      frac    = ext >> (int'(NF) - p_nf);
      dropped = |(ext & ~(OnesW << (int'(NF) - p_nf)));
    end else begin
      frac    = ext << (p_nf - int'(NF));
      dropped = 1'b0;
    end
    emask        = (OneW << p_e) - OneW;
    w_e          = fmt_e(WideFmt);
    w_nf         = fmt_nf(WideFmt);
    word         = '0;
    pk_inexact   = 1'b0;
    pk_overflow  = 1'b0;
    pk_underflow = 1'b0;
    if (!cur_supported) begin
      word  = (((OneW << w_e) - OneW) << w_nf) | (OneW << (w_nf - 1));
      box_w = 1 + w_e + w_nf;
    end else if (!use_shift && XNaN) begin
      word = (emask << p_nf) | (OneW << (p_nf - 1));
    end else if (!use_shift && XInf) begin
      word = (PW'(p_sign) << (p_e + p_nf)) | (emask << p_nf);
    end else if (!use_shift && XZero) begin
      word = PW'(p_sign) << (p_e + p_nf);
    end else if (use_shift) begin
      // Exponent field is zero; leading bit has already moved into the fraction
      word         = (PW'(p_sign) << (p_e + p_nf)) | frac;
      pk_inexact   = sticky_sh | dropped;
      pk_underflow = sticky_sh | dropped;
    end else if (et_i >= (1 << p_e) - 1) begin
      word        = (PW'(p_sign) << (p_e + p_nf)) | (emask << p_nf);
      pk_inexact  = 1'b1;
      pk_overflow = 1'b1;
    end else begin
      word       = (PW'(p_sign) << (p_e + p_nf)) | (PW'(et_i) << p_nf) | frac;
      pk_inexact = dropped;
    end
    pk_result = FLEN'(word | (OnesW << box_w));
  end

  // Next-state: capture in IDLE, shift one bit per cycle, hold the result in DONE
  always_comb begin
    state_d     = state_q;
    fmt_d       = fmt_q;
    sign_d      = sign_q;
    mant_d      = mant_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    inexact_d   = inexact_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    case (state_q)
      StIdle: begin
        if (InValid) begin
          fmt_d    = Fmt[1:0];
          sign_d   = Xs;
          mant_d   = Xm;
          sticky_d = 1'b0;
          if (XNaN || XInf || XZero || !cur_supported || (et_i >= 1)) begin
            state_d     = StDone;
            result_d    = pk_result;
            inexact_d   = pk_inexact;
            overflow_d  = pk_overflow;
            underflow_d = pk_underflow;
          end else begin
            // Beyond Nf+2 shifts every significant bit is already in the sticky
            cnt_d   = ((1 - et_i) < (p_nf + 2)) ? CntW'(1 - et_i) : CntW'(p_nf + 2);
            state_d = StShift;
          end
        end
      end
      StShift: begin
        mant_d   = mant_sh;
        sticky_d = sticky_sh;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d     = StDone;
          result_d    = pk_result;
          inexact_d   = pk_inexact;
          overflow_d  = pk_overflow;
          underflow_d = pk_underflow;
        end
      end
      StDone: begin
        if (OutReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      fmt_q       <= 2'b00;
      sign_q      <= 1'b0;
      mant_q      <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      sign_q      <= sign_d;
      mant_q      <= mant_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      inexact_q   <= inexact_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign InReady   = (state_q == StIdle);
  assign OutValid  = (state_q == StDone);
  assign Result    = result_q;
  assign Inexact   = inexact_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

endmodule

// File: tb/tb_fpack_seq.sv
// tb_fpack_seq: directed and randomized checks of fpack_seq against a reference model
// that packs values with plain arithmetic from the format table.
module tb_fpack_seq;

  logic        clk = 1'b0;
  logic        reset, InValid, InReady, Xs, XNaN, XInf, XZero;
  logic        OutValid, OutReady, Inexact, Overflow, Underflow;
  logic [1:0]  Fmt;
  logic [10:0] Xe;
  logic [52:0] Xm;
  logic [63:0] Result;

  int total = 0;
  int bad   = 0;

  logic [63:0] o_res;
  logic [2:0]  o_flags;
  int          o_lat;

  always #5 clk = ~clk;

  fpack_seq #(.FLEN(64), .NE(11), .NF(52), .FMTBITS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .Fmt       (Fmt),
    .Xs        (Xs),
    .Xe        (Xe),
    .Xm        (Xm),
    .XNaN      (XNaN),
    .XInf      (XInf),
    .XZero     (XZero),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Result    (Result),
    .Inexact   (Inexact),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  // Reference: flags returned as {Inexact, Overflow, Underflow}; lat = cycles after accept
  function automatic void model(input logic [1:0] f, input logic s, input logic [10:0] xe,
                                input logic [52:0] xm, input logic nan, input logic inf,
                                input logic zero, output logic [63:0] res,
                                output logic [2:0] fl, output int lat);
    int e, nf, bias, w, emax, et, k;
    logic [127:0] one, ones, bits, full, fr, sgn;
    logic lost, drop;
    one  = 128'd1;
    ones = '1;
    case (f)
      2'b00:   begin e = 8;  nf = 23;  end
      2'b01:   begin e = 11; nf = 52;  end
      2'b10:   begin e = 5;  nf = 10;  end
      default: begin e = 15; nf = 112; end
    endcase
    bias = (1 << (e - 1)) - 1;
    emax = (1 << e) - 1;
    w    = 1 + e + nf;
    fl   = 3'b000;
    lat  = 1;
    sgn  = 128'(s) << (e + nf);
    if (w > 64) begin
      res = 64'h7FF8000000000000;
      return;
    end
    if (nan) bits = (128'(emax) << nf) | (one << (nf - 1));
    else if (inf) bits = sgn | (128'(emax) << nf);
    else if (zero) bits = sgn;
    else begin
      et = int'(xe) - 1023 + bias;
      if (et >= emax) begin
        bits = sgn | (128'(emax) << nf);
        fl   = 3'b110;
      end else if (et >= 1) begin
        fr   = 128'(xm[51:0]) >> (52 - nf);
        drop = (128'(xm[51:0]) << (76 + nf)) != 0;
        bits = sgn | (128'(et) << nf) | fr;
        fl   = {drop, 2'b00};
      end else begin
        k    = (1 - et < nf + 2) ? 1 - et : nf + 2;
        lat  = 1 + k;
        full = 128'(xm) >> k;
        lost = (128'(xm) << (128 - k)) != 0;
        fr   = 128'(full[51:0]) >> (52 - nf);
        drop = (128'(full[51:0]) << (76 + nf)) != 0;
        bits = sgn | fr;
        fl   = {lost | drop, 1'b0, lost | drop};
      end
    end
    res = 64'(bits | (ones << w));
  endfunction

  // Drive one operand with OutReady high; record result, flags and latency
  task automatic do_op(input logic [1:0] f, input logic s, input logic [10:0] xe,
                       input logic [52:0] xm, input logic nan, input logic inf,
                       input logic zero);
    Fmt = f; Xs = s; Xe = xe; Xm = xm; XNaN = nan; XInf = inf; XZero = zero;
    InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    o_lat = 1;
    while (!OutValid && o_lat < 200) begin
      @(posedge clk); #1;
      o_lat++;
    end
    o_res   = Result;
    o_flags = {Inexact, Overflow, Underflow};
    if (OutValid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    Fmt = 2'b00; Xs = 1'b0; Xe = '0; Xm = '0; XNaN = 1'b0; XInf = 1'b0; XZero = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL reset InReady: got %b want 1", InReady); end
    total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset OutValid: got %b want 0", OutValid); end
    total++; if (Result !== 64'h0) begin bad++; $display("FAIL reset Result: got %h want 0", Result); end
    total++; if ({Inexact, Overflow, Underflow} !== 3'b000) begin
      bad++; $display("FAIL reset flags: got %b want 000", {Inexact, Overflow, Underflow});
    end
  endtask

  typedef struct {
    logic [1:0]  f;
    logic        s;
    logic [10:0] xe;
    logic [52:0] xm;
    logic        nan;
    logic        inf;
    logic [63:0] res;
    logic [2:0]  fl;
    int          lat;
  } vec_t;

  task automatic test_directed;
    vec_t v[8];
    v[0] = '{2'b00, 1'b0, 11'h3FF, 53'h10000000000000, 1'b0, 1'b0, 64'hFFFFFFFF3F800000, 3'b000, 1};
    v[1] = '{2'b00, 1'b0, 11'h380, 53'h10000000000000, 1'b0, 1'b0, 64'hFFFFFFFF00400000, 3'b000, 2};
    v[2] = '{2'b00, 1'b0, 11'h4C7, 53'h10000000000000, 1'b0, 1'b0, 64'hFFFFFFFF7F800000, 3'b110, 1};
    v[3] = '{2'b10, 1'b0, 11'h000, 53'h0, 1'b1, 1'b0, 64'hFFFFFFFFFFFF7E00, 3'b000, 1};
    v[4] = '{2'b11, 1'b0, 11'h000, 53'h0, 1'b1, 1'b0, 64'h7FF8000000000000, 3'b000, 1};
    v[5] = '{2'b10, 1'b0, 11'h300, 53'h10000000000001, 1'b0, 1'b0, 64'hFFFFFFFFFFFF0000, 3'b101, 13};
    v[6] = '{2'b01, 1'b1, 11'h3FF, 53'h18000000000000, 1'b0, 1'b0, 64'hBFF8000000000000, 3'b000, 1};
    v[7] = '{2'b10, 1'b1, 11'h000, 53'h0, 1'b1, 1'b1, 64'hFFFFFFFFFFFF7E00, 3'b000, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].f, v[i].s, v[i].xe, v[i].xm, v[i].nan, v[i].inf, 1'b0);
      total++; if (o_res !== v[i].res) begin
        bad++; $display("FAIL dir%0d result: got %h want %h", i, o_res, v[i].res);
      end
      total++; if (o_flags !== v[i].fl) begin
        bad++; $display("FAIL dir%0d flags: got %b want %b", i, o_flags, v[i].fl);
      end
      total++; if (o_lat !== v[i].lat) begin
        bad++; $display("FAIL dir%0d latency: got %0d want %0d", i, o_lat, v[i].lat);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  f;
    logic        s, nan, inf, zero;
    logic [10:0] xe;
    logic [52:0] xm;
    logic [63:0] er;
    logic [2:0]  ef;
    int          el, e, nf, bias, ett, xei, sel;
    for (int i = 0; i < 60; i++) begin
      f = 2'($urandom_range(0, 3));
      s = 1'($urandom);
      case (f)
        2'b00:   begin e = 8;  nf = 23; end
        2'b01:   begin e = 11; nf = 52; end
        default: begin e = 5;  nf = 10; end
      endcase
      bias = (1 << (e - 1)) - 1;
      ett  = int'($urandom_range(0, ((1 << e) - 1) + nf + 10)) - (nf + 8);
      xei  = ett + 1023 - bias;
      if (xei < 0) xei = 0;
      if (xei > 2047) xei = 2047;
      xe = 11'(xei);
      xm = {1'b1, 20'($urandom), $urandom};
      if ($urandom_range(0, 1) == 1) xm[39:0] = '0;
      sel  = int'($urandom_range(0, 11));
      nan  = (sel == 0);
      inf  = (sel == 1) || (sel == 0 && $urandom_range(0, 1) == 1);
      zero = (sel == 2) || (sel == 1 && $urandom_range(0, 1) == 1);
      model(f, s, xe, xm, nan, inf, zero, er, ef, el);
      do_op(f, s, xe, xm, nan, inf, zero);
      total++; if (o_res !== er) begin
        bad++; $display("FAIL rand%0d result: got %h want %h (fmt %b xe %h)", i, o_res, er, f, xe);
      end
      total++; if (o_flags !== ef) begin
        bad++; $display("FAIL rand%0d flags: got %b want %b", i, o_flags, ef);
      end
      total++; if (o_lat !== el) begin
        bad++; $display("FAIL rand%0d latency: got %0d want %0d", i, o_lat, el);
      end
    end
  endtask

  task automatic test_backpressure;
    OutReady = 1'b0;
    Fmt = 2'b00; Xs = 1'b0; Xe = 11'h3FF; Xm = 53'h10000000000000;
    XNaN = 1'b0; XInf = 1'b0; XZero = 1'b0;
    InValid = 1'b1;
    @(posedge clk); #1;
    Xe = 11'h400; Fmt = 2'b10;
    total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL bp OutValid: got %b want 1", OutValid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (Result !== 64'hFFFFFFFF3F800000) begin
        bad++; $display("FAIL bp%0d hold Result: got %h want FFFFFFFF3F800000", i, Result);
      end
      total++; if ({InReady, OutValid} !== 2'b01) begin
        bad++; $display("FAIL bp%0d InReady/OutValid: got %b want 01", i, {InReady, OutValid});
      end
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    total++; if ({InReady, OutValid} !== 2'b10) begin
      bad++; $display("FAIL bp release InReady/OutValid: got %b want 10", {InReady, OutValid});
    end
    @(posedge clk); #1;
    total++; if (OutValid !== 1'b0) begin
      bad++; $display("FAIL bp no second capture OutValid: got %b want 0", OutValid);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic seen;
    Fmt = 2'b10; Xs = 1'b0; Xe = 11'h300; Xm = 53'h10000000000001;
    XNaN = 1'b0; XInf = 1'b0; XZero = 1'b0;
    InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if ({InReady, OutValid} !== 2'b00) begin
      bad++; $display("FAIL midshift busy InReady/OutValid: got %b want 00", {InReady, OutValid});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if ({InReady, OutValid} !== 2'b10) begin
      bad++; $display("FAIL midshift after reset InReady/OutValid: got %b want 10", {InReady, OutValid});
    end
    total++; if (Result !== 64'h0) begin
      bad++; $display("FAIL midshift after reset Result: got %h want 0", Result);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (OutValid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin
      bad++; $display("FAIL midshift stray OutValid: got %b want 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_mid_shift;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpack_seq.md
Name: fpack_seq

Overview:
- Inverse of the FPU input unpacker: takes a value in the internal maximum-precision form (sign, biased exponent, mantissa with explicit leading bit, special-case flags) and packs it into the IEEE encoding of the format selected by Fmt.
- Output is NaN-boxed to FLEN bits.
- Sits between the FPU result path and the FP register-file write port.
- Subnormal denormalization is iterative, one bit per cycle, behind valid/ready handshakes.

Parameters:
- FLEN, 64: width of FP registers and of Result.
- NE, 11: exponent width of the maximum-precision internal format.
- NF, 52: fraction width of the maximum-precision internal format.
- FMTBITS, 2: width of Fmt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- InValid  in  1  input operand valid
- InReady  out  1  block can accept an operand
- Fmt  in  FMTBITS  target format: 00 single, 01 double, 10 half, 11 quad
- Xs  in  1  sign
- Xe  in  NE  exponent, biased with BiasMax = 2^(NE-1)-1
- Xm  in  NF+1  mantissa; bit NF is the explicit leading bit
- XNaN, XInf, XZero  in  1 each  special-case flags; priority NaN > Inf > Zero
- OutValid  out  1  Result and flags valid
- OutReady  in  1  consumer accepts Result
- Result  out  FLEN  packed, NaN-boxed value
- Inexact, Overflow, Underflow  out  1 each  exception flags qualified by OutValid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE; InReady=1.
  - OutValid=0; Result=0; all flags=0; shift counter=0.
- Format table (target exponent width, target fraction width Nf, target bias):
  - S: 8, 23, 127.
  - D: 11, 52, 1023.
  - H: 5, 10, 15.
  - Q: 15, 112, 16383.
  - A format is unsupported if its width > FLEN.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - InReady=1.
  - On InValid, capture all inputs and compute Et = Xe - BiasMax + Bias_fmt as a signed (NE+2)-bit value.
  - Special case, unsupported Fmt, or Et >= 1: go to DONE.
  - Otherwise (finite, Et <= 0): count = min(1-Et, Nf+2), go to SHIFT.
- SHIFT:
  - Each cycle: mantissa >>= 1; sticky |= bit shifted out; count--.
  - When count reaches 1 in this cycle, go to DONE.
  - Exponent field is 0 on exit.
- DONE:
  - OutValid=1; Result and flags held stable while OutReady=0.
  - On OutReady, go to IDLE.
  - InReady=0 in SHIFT and DONE; InValid is ignored there.
- Latency: the accept edge plus 1 cycle when no shift is needed, otherwise plus (1 + count). Minimum initiation interval is 2 cycles.
- Packing rules:
  - Fraction is the top Nf bits below bit NF of the (shifted) mantissa, truncated toward zero.
  - Inexact = sticky OR (dropped lower mantissa bits != 0).
  - Underflow = Inexact AND the result is subnormal or zero from shifting.
- Overflow: Et >= 2^E_fmt - 1 gives signed Inf, with Overflow=1 and Inexact=1.
- Specials:
  - NaN gives the canonical NaN: sign 0, exponent all 1s, fraction MSB 1, rest 0.
  - Inf gives signed Inf.
  - Zero gives signed zero.
  - All specials leave flags at 0.
- Unsupported Fmt: output the canonical NaN of the widest supported format; flags 0.
- NaN-boxing: Result bits above the format width are all 1s. Double with FLEN=64 is unboxed.
- Reset mid-SHIFT or mid-DONE: operation is aborted with no OutValid pulse; reset values apply the next cycle.
- Truncation only. Rounding is done upstream; the inputs are assumed already rounded to Nf.

Test Plan:
- Single 1.0: Xe=0x3FF, Xm=1<<52, Fmt=00. Required: Result=0xFFFFFFFF3F800000, flags 0, OutValid 1 cycle after accept.
- Single subnormal 2^-127: Xe=0x380, Xm=1<<52, Fmt=00. Required: Et=0 and count=1; Result=0xFFFFFFFF00400000; Underflow=0, Inexact=0; OutValid 2 cycles after accept.
- Overflow 2^200 to single: Xe=0x4C7. Required: Result=0xFFFFFFFF7F800000, Overflow=1, Inexact=1.
- Half NaN: XNaN=1, Fmt=10. Required: Result=0xFFFFFFFFFFFF7E00. Quad Fmt=11 with FLEN=64 gives Result=0x7FF8000000000000.
- Backpressure: hold OutReady=0 for 3 cycles in DONE with InValid=1. Required: Result stable, InReady=0, no second capture; OutReady=1 returns the FSM to IDLE with InReady=1.
- Deep underflow Xe=0x300, Xm=(1<<52)|1, Fmt=10: count clamps to 12. Required: Result=0xFFFFFFFFFFFF0000, Inexact=1, Underflow=1. A repeat run with reset asserted in the 5th SHIFT cycle gives no OutValid and InReady=1 on the next cycle.
